// File: rtl/posi_md_ram_sp_ctl_pkg.sv
// Shared types for the mode-decision single-port RAM controller: clear-FSM
// state encoding and the clear-counter width helper.
package posi_md_ram_sp_ctl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } state_t;

    // ceil(log2(depth)), never below 1 so a one-word RAM still gets a counter bit
    function automatic int cnt_wd(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/posi_md_ram_sp_core.sv
// Behavioural 2^ADR_WD x PHY_WD single-port array: low-active cen/wen, synchronous
// read with 1-cycle latency, Q holds when not read; no backpressure (one access per cycle).
module posi_md_ram_sp_core #(
    parameter int ADR_WD = 6,
    parameter int PHY_WD = 8
) (
    input  logic              clk,
    input  logic              i_cen_n,
    input  logic              i_wen_n,
    input  logic              i_oen_n,
    input  logic [ADR_WD-1:0] i_adr,
    input  logic [PHY_WD-1:0] i_dat,
    output logic [PHY_WD-1:0] o_q
);

    logic [PHY_WD-1:0] r_mem [0:(1 << ADR_WD)-1];
    logic [PHY_WD-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!i_cen_n) begin
            if (!i_wen_n) begin
                r_mem[i_adr] <= i_dat;
            end else begin
                r_q <= r_mem[i_adr];
            end
        end
    end

    assign o_q = i_oen_n ? '0 : r_q;

endmodule

// File: rtl/posi_md_ram_sp_ctl.sv
// Single-port RAM controller with clear engine, write-through and range check.
// Read latency 1 cycle; no backpressure, accesses are silently ignored while busy_o is high.
module posi_md_ram_sp_ctl
    import posi_md_ram_sp_ctl_pkg::*;
#(
    parameter int ADR_WD     = 6,
    parameter int DEPTH      = 64,
    parameter int DAT_WD     = 6,
    parameter int PHY_WD     = 8,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [ADR_WD-1:0] adr_i,
    input  logic              wr_ena_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    input  logic              rd_ena_i,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic              rd_vld_o,
    output logic              busy_o,
    output logic              adr_err_o
);

    localparam int                CNT_WD   = cnt_wd(DEPTH);
    localparam state_t            RST_ST   = (CLR_ON_RST != 0) ? ST_CLR : ST_IDLE;
    localparam logic [CNT_WD-1:0] LAST_ADR = CNT_WD'(DEPTH - 1);

    state_t            r_state;
    state_t            w_nxt_state;
    logic [CNT_WD-1:0] r_cnt;
    logic [CNT_WD-1:0] w_nxt_cnt;
    logic [CNT_WD-1:0] w_clr_adr;

    logic              w_clr_wr;
    logic              w_acc;
    logic              w_in_rng;
    logic              w_wr;
    logic              w_rd;
    logic              w_mac_wr;
    logic              w_mac_rd;
    logic              w_cen_n;
    logic              w_wen_n;
    logic [ADR_WD-1:0] w_mac_adr;
    logic [PHY_WD-1:0] w_mac_dat;
    logic [PHY_WD-1:0] w_q;

    logic              r_rd_vld;
    logic              r_adr_err;
    logic              r_sel_q;
    logic [DAT_WD-1:0] r_byp_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_ST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // A clear request inside a clear rewrites address 0 in that same cycle
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_clr_adr   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_i) begin
                    w_nxt_state = ST_CLR;
                    w_nxt_cnt   = '0;
                end
            end
            ST_CLR: begin
                if (clr_i) begin
                    w_clr_adr = '0;
                end
                if (w_clr_adr == LAST_ADR) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = w_clr_adr + CNT_WD'(1);
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    assign busy_o   = (r_state == ST_CLR);
    assign w_clr_wr = busy_o && !rst;
    assign w_acc    = (r_state == ST_IDLE) && !clr_i && !rst;
    assign w_in_rng = ({1'b0, adr_i} < (ADR_WD + 1)'(DEPTH));

    assign w_wr     = w_acc && !wr_ena_i;
    assign w_rd     = w_acc && !rd_ena_i;
    assign w_mac_wr = w_wr && w_in_rng;
    assign w_mac_rd = w_rd && wr_ena_i && w_in_rng;

    assign w_cen_n   = !(w_clr_wr || w_mac_wr || w_mac_rd);
    assign w_wen_n   = !(w_clr_wr || w_mac_wr);
    assign w_mac_adr = w_clr_wr ? ADR_WD'(w_clr_adr) : adr_i;
    assign w_mac_dat = w_clr_wr ? '0 : PHY_WD'(wr_dat_i);

`ifdef POSI_MD_RAM_HARD_MACRO
    posi_md_ram_sp_macro u_mem (
        .clk     (clk),
        .i_cen_n (w_cen_n),
        .i_wen_n (w_wen_n),
        .i_oen_n (1'b0),
        .i_adr   (w_mac_adr),
        .i_dat   (w_mac_dat),
        .o_q     (w_q)
    );
`else
    posi_md_ram_sp_core #(
        .ADR_WD (ADR_WD),
        .PHY_WD (PHY_WD)
    ) u_mem (
        .clk     (clk),
        .i_cen_n (w_cen_n),
        .i_wen_n (w_wen_n),
        .i_oen_n (1'b0),
        .i_adr   (w_mac_adr),
        .i_dat   (w_mac_dat),
        .o_q     (w_q)
    );
`endif

    // Macro Q is itself the read capture register and only moves on a macro read,
    // so r_sel_q just records whether the latest read came from the macro or the bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_adr_err <= 1'b0;
            r_sel_q   <= 1'b0;
            r_byp_dat <= '0;
        end else begin
            r_rd_vld  <= w_rd;
            r_adr_err <= (w_wr || w_rd) && !w_in_rng;
            if (w_rd) begin
                r_sel_q   <= w_mac_rd;
                r_byp_dat <= w_in_rng ? wr_dat_i : '0;
            end
        end
    end

    generate
        if (PHY_WD > DAT_WD) begin : g_pad
            logic w_pad_unused;
            assign w_pad_unused = ^w_q[PHY_WD-1:DAT_WD];
        end
    endgenerate

    assign rd_dat_o  = r_sel_q ? w_q[DAT_WD-1:0] : r_byp_dat;
    assign rd_vld_o  = r_rd_vld;
    assign adr_err_o = r_adr_err;

endmodule

// File: tb/tb_posi_md_ram_sp_ctl.sv
// Bench for posi_md_ram_sp_ctl: DEPTH=64 and DEPTH=48 instances share one stimulus
// stream; a per-instance memory/busy model feeds a scoreboard checked every cycle.
module tb_posi_md_ram_sp_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_i;
    logic [5:0] adr_i;
    logic       wr_ena_i;
    logic [5:0] wr_dat_i;
    logic       rd_ena_i;

    logic [1:0][5:0] rd_dat;
    logic [1:0]      rd_vld;
    logic [1:0]      busy;
    logic [1:0]      adr_err;

    always #5 clk = ~clk;

    posi_md_ram_sp_ctl #(
        .ADR_WD(6), .DEPTH(64), .DAT_WD(6), .PHY_WD(8), .CLR_ON_RST(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .clr_i(clr_i), .adr_i(adr_i),
        .wr_ena_i(wr_ena_i), .wr_dat_i(wr_dat_i), .rd_ena_i(rd_ena_i),
        .rd_dat_o(rd_dat[0]), .rd_vld_o(rd_vld[0]), .busy_o(busy[0]),
        .adr_err_o(adr_err[0])
    );

    posi_md_ram_sp_ctl #(
        .ADR_WD(6), .DEPTH(48), .DAT_WD(6), .PHY_WD(8), .CLR_ON_RST(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .clr_i(clr_i), .adr_i(adr_i),
        .wr_ena_i(wr_ena_i), .wr_dat_i(wr_dat_i), .rd_ena_i(rd_ena_i),
        .rd_dat_o(rd_dat[1]), .rd_vld_o(rd_vld[1]), .busy_o(busy[1]),
        .adr_err_o(adr_err[1])
    );

    typedef struct {
        int         d;
        logic       vld;
        logic       err;
        logic [5:0] dat;
    } exp_t;

    typedef struct {
        logic       wr_n;
        logic       rd_n;
        logic [5:0] adr;
        logic [5:0] dat;
        logic       a_vld;
        logic       a_err;
        logic [5:0] a_dat;
        logic       b_vld;
        logic       b_err;
        logic [5:0] b_dat;
    } vec_t;

    exp_t       sb[$];
    vec_t       tv[$];
    logic [5:0] m_mem[2][64];
    int         m_left[2];
    logic [5:0] m_hold[2];
    int         vec_cnt = 0;
    int         err_cnt = 0;

    function automatic int depth_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_left[d] = depth_of(d);
            m_hold[d] = '0;
            for (int a = 0; a < 64; a++) m_mem[d][a] = '0;
        end
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; clr_i = 1'b0; wr_ena_i = 1'b1; rd_ena_i = 1'b1;
        adr_i = '0; wr_dat_i = '0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rd_dat", d, 32'(rd_dat[d]), 32'h0);
            chk("rst_rd_vld", d, 32'(rd_vld[d]), 32'h0);
            chk("rst_adr_err", d, 32'(adr_err[d]), 32'h0);
            chk("rst_busy", d, 32'(busy[d]), 32'h1);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, predict, clock, compare.
    task automatic step(input logic wr_n, input logic rd_n, input logic [5:0] adr,
                        input logic [5:0] dat, input logic clr);
        exp_t e;
        logic acc;
        logic inr;
        wr_ena_i = wr_n; rd_ena_i = rd_n; adr_i = adr; wr_dat_i = dat; clr_i = clr;
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, 32'(busy[d]), 32'(m_left[d] != 0));
            acc   = (m_left[d] == 0) && !clr;
            inr   = (int'(adr) < depth_of(d));
            e.d   = d;
            e.vld = acc && !rd_n;
            e.err = acc && (!wr_n || !rd_n) && !inr;
            e.dat = !inr ? 6'h00 : (!wr_n ? dat : m_mem[d][adr]);
            if (acc && !wr_n && inr) m_mem[d][adr] = dat;
            if (e.vld || e.err) sb.push_back(e);
            if (clr) begin
                m_left[d] = (m_left[d] == 0) ? depth_of(d) : depth_of(d) - 1;
                for (int a = 0; a < 64; a++) m_mem[d][a] = '0;
            end else if (m_left[d] > 0) begin
                m_left[d]--;
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            if (sb.size() > 0 && sb[0].d == d) begin
                e = sb.pop_front();
                chk("rd_vld", d, 32'(rd_vld[d]), 32'(e.vld));
                chk("adr_err", d, 32'(adr_err[d]), 32'(e.err));
                if (e.vld) m_hold[d] = e.dat;
            end else begin
                chk("rd_vld_idle", d, 32'(rd_vld[d]), 32'h0);
                chk("adr_err_idle", d, 32'(adr_err[d]), 32'h0);
            end
            chk("rd_dat", d, 32'(rd_dat[d]), 32'(m_hold[d]));
        end
    endtask

    task automatic add(input logic wr_n, input logic rd_n, input logic [5:0] adr, input logic [5:0] dat,
                       input logic av, input logic ae, input logic [5:0] ad,
                       input logic bv, input logic be, input logic [5:0] bd);
        vec_t v;
        v.wr_n = wr_n; v.rd_n = rd_n; v.adr = adr; v.dat = dat;
        v.a_vld = av; v.a_err = ae; v.a_dat = ad;
        v.b_vld = bv; v.b_err = be; v.b_dat = bd;
        tv.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nb_a;
        int nb_b;

        // wr_n rd_n adr dat | A: vld err dat | B: vld err dat
        add(0, 1, 6'd5, 6'h2A, 0, 0, 6'h00, 0, 0, 6'h00);
        for (int i = 0; i < 3; i++) add(1, 1, 6'd0, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00);
        add(1, 0, 6'd5, 6'h00, 1, 0, 6'h2A, 1, 0, 6'h2A);
        for (int i = 0; i < 10; i++) add(1, 1, 6'd0, 6'h00, 0, 0, 6'h2A, 0, 0, 6'h2A);
        add(0, 0, 6'd9, 6'h15, 1, 0, 6'h15, 1, 0, 6'h15);
        add(1, 1, 6'd0, 6'h00, 0, 0, 6'h15, 0, 0, 6'h15);
        add(1, 0, 6'd9, 6'h00, 1, 0, 6'h15, 1, 0, 6'h15);
        add(0, 1, 6'd50, 6'h3F, 0, 0, 6'h15, 0, 1, 6'h15);
        add(1, 0, 6'd50, 6'h00, 1, 0, 6'h3F, 1, 1, 6'h00);
        add(1, 0, 6'd2, 6'h00, 1, 0, 6'h00, 1, 0, 6'h00);

        do_reset();

        // Clear after reset lasts exactly DEPTH cycles
        n = 0;
        while (busy[0] && n < 200) begin
            step(1, 1, 6'd0, 6'h00, 0);
            n++;
        end
        chk("busy_len_after_rst", 0, 32'(n), 32'd64);
        for (int a = 0; a < 64; a++) step(1, 0, 6'(a), 6'h00, 0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].wr_n, tv[i].rd_n, tv[i].adr, tv[i].dat, 0);
            chk("tv_vld", 0, 32'(rd_vld[0]), 32'(tv[i].a_vld));
            chk("tv_err", 0, 32'(adr_err[0]), 32'(tv[i].a_err));
            chk("tv_dat", 0, 32'(rd_dat[0]), 32'(tv[i].a_dat));
            chk("tv_vld", 1, 32'(rd_vld[1]), 32'(tv[i].b_vld));
            chk("tv_err", 1, 32'(adr_err[1]), 32'(tv[i].b_err));
            chk("tv_dat", 1, 32'(rd_dat[1]), 32'(tv[i].b_dat));
        end

        // Reset in the middle of a clear
        step(1, 0, 6'd9, 6'h00, 0);
        step(1, 1, 6'd0, 6'h00, 1);
        for (int i = 0; i < 30; i++) step(1, 1, 6'd0, 6'h00, 0);
        do_reset();
        n = 0;
        while (busy[0] && n < 200) begin
            step(1, 1, 6'd0, 6'h00, 0);
            n++;
        end
        chk("busy_len_after_mid_rst", 0, 32'(n), 32'd64);

        // Fill, clear, re-request clear at clear cycle 20, read through busy
        for (int a = 0; a < 64; a++) step(0, 1, 6'(a), 6'(a), 0);
        step(1, 0, 6'd7, 6'h00, 0);
        chk("fill_rd7", 0, 32'(rd_dat[0]), 32'h07);
        nb_a = 0;
        nb_b = 0;
        for (int k = 0; k < 100; k++) begin
            step(1, 0, 6'(k % 64), 6'h00, (k == 0) || (k == 21));
            if (busy[0]) nb_a++;
            if (busy[1]) nb_b++;
        end
        chk("busy_len_reclear", 0, 32'(nb_a), 32'd84);
        chk("busy_len_reclear", 1, 32'(nb_b), 32'd68);
        for (int a = 0; a < 64; a++) step(1, 0, 6'(a), 6'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
